sgm_pipe_ctrl: RTL and testbench
================================

# sgm_pipe_ctrl

Frame-level sequencer for a chain of clock-enabled `delay` stages in the SGM datapath. It generates the single shared `ce` that every stage in the chain uses, and tracks per-stage valid bits. It applies valid/ready flow control at both ends of the chain and produces output pixel coordinates and frame/line markers aligned with the last stage. One `start` pulse processes exactly one WIDTH×HEIGHT frame, then the pipeline drains and `done` pulses.

## Interface
- `DEPTH`, 3: number of `delay` stages driven by `ce` (≥1).
- `WIDTH`, 640: pixels per line (≥2).
- `HEIGHT`, 480: lines per frame (≥1).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin one frame; honoured only in IDLE.
- `in_valid`  in  1  upstream pixel present.
- `in_ready`  out  1  controller accepts the upstream pixel this cycle.
- `out_ready`  in  1  downstream accepts the pixel at the last stage.
- `out_valid`  out  1  last stage holds a valid pixel.
- `ce`  out  1  shared clock enable for all DEPTH stages.
- `stage_valid`  out  DEPTH  valid bit per stage; bit 0 is the first stage.
- `out_x`  out  $clog2(WIDTH)  column of the pixel at the output.
- `out_y`  out  $clog2(HEIGHT) (min 1)  line of the pixel at the output.
- `out_sol`, `out_eol`, `out_sof`, `out_eof`  out  1 each  start/end of line/frame markers for the output pixel.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last output pixel is accepted.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DRAIN when the input beat count reaches WIDTH*HEIGHT.
  - DRAIN → IDLE when the last output beat is accepted.
- `start` is ignored while in RUN or DRAIN.
- Advance:
  - In RUN and DRAIN, `ce = out_ready | ~stage_valid[DEPTH-1]`.
  - In IDLE, `ce = 0`, so the stages hold their data.
- `in_ready = ce` in RUN; `in_ready = 0` in IDLE and DRAIN.
- Input beat: `in_valid & in_ready`. The input counter increments on each beat and clears on the RUN→DRAIN transition.
- On `ce`:
  - `stage_valid[0] <= in_valid & in_ready`.
  - `stage_valid[i] <= stage_valid[i-1]` for i ≥ 1.
  - Bubbles (cycles with no input beat) propagate as invalid slots. They are not collapsed.
- `out_valid = stage_valid[DEPTH-1]`.
- Output beat: `out_valid & out_ready`.
- Output counters `out_x` and `out_y` start at 0. On each output beat:
  - x increments.
  - At x = WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0.
- Markers are combinational from the counters and are meaningful only when `out_valid = 1`:
  - `out_sol`: x = 0.
  - `out_eol`: x = WIDTH-1.
  - `out_sof`: x = 0 and y = 0.
  - `out_eof`: x = WIDTH-1 and y = HEIGHT-1.
- `done` is registered high for exactly the cycle after the output beat with `out_eof`. The state is IDLE in that same cycle.
- The controller never touches the stage data. Data correctness relies only on `ce`.

## Timing
- Reset values:
  - state IDLE.
  - `stage_valid` 0, so `out_valid` 0.
  - `in_ready` 0, `ce` 0.
  - All counters 0, so `out_sol`/`out_sof` read 1 but are qualified by `out_valid`.
  - `busy` 0, `done` 0.
- `busy` goes high the cycle after `start` is sampled.
- Latency: an input beat at cycle t appears as `out_valid` at t+DEPTH when `ce` is held at 1.
- Throughput: 1 pixel/cycle while `out_ready = 1`.
- Backpressure:
  - With the last stage valid and `out_ready = 0`, `ce = 0` and `in_ready = 0` in the same cycle.
  - All stages hold.
  - No beat is lost or duplicated.
- Boundary conditions:
  - **Last input beat:** in the cycle the counter reaches WIDTH*HEIGHT, the transition to DRAIN occurs and `in_ready` is 0 from the next cycle onward.
  - **Drain:** DRAIN keeps advancing `ce` until the eof beat is accepted.
  - **Reset:** `rst` in any state returns every output to its reset value on the next edge. In-flight stage data is invalidated via `stage_valid`.
  - **Reset vs. start:** `rst` and `start` in the same cycle resolve to reset.
  - **Minimum depth:** DEPTH = 1 is legal; `stage_valid[0]` is the output.

## Test plan
Common setup: DEPTH=3, WIDTH=4, HEIGHT=2.
- **Reset and idle:** `rst` high, then low; `in_valid = 1`, no `start` → `in_ready`, `ce`, `out_valid`, `busy` and `done` all stay 0 for 20 cycles.
- **Streaming frame:** `start` pulse; `in_valid` and `out_ready` held at 1 → 8 input beats on consecutive cycles, and the first `out_valid` 3 cycles after the first beat.
  - (x,y) runs (0,0)…(3,0),(0,1)…(3,1).
  - `out_sol` on x = 0, `out_eol` on x = 3.
  - `out_sof` on beat 1, `out_eof` on beat 8.
  - `done` high one cycle after beat 8; `busy` 0 in that same cycle.
- **Backpressure:** `out_ready = 0` for 5 cycles mid-frame → `ce = 0` and `in_ready = 0` throughout; `stage_valid = 3'b111` held; the output sequence is identical to the streaming case.
- **Bubbles:** `in_valid` toggled 1,0,1,0… → `stage_valid` shows alternating bits; the 8 output beats are in order and `done` fires once.
- **Start ignored:** `start` re-pulsed during RUN and DRAIN → no counter or state change; exactly one `done`.
- **Reset mid-frame:** `rst` after 5 input beats → next cycle is IDLE with all outputs at reset values; a new `start` runs a full 8-beat frame from (0,0).

Source files
------------

// File: rtl/sgm_pipe_ctrl_if.sv
// Handshake and status bundle between the SGM pipeline controller and its environment.
// The controller takes the slave view; the environment driving start/in_valid/out_ready takes master.
interface sgm_pipe_ctrl_if #(
  parameter int DEPTH  = 3,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic             ce;
  logic [DEPTH-1:0] stage_valid;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;
  logic             out_sol;
  logic             out_eol;
  logic             out_sof;
  logic             out_eof;
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, out_valid, ce, stage_valid, out_x, out_y,
           out_sol, out_eol, out_sof, out_eof, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, out_valid, ce, stage_valid, out_x, out_y,
           out_sol, out_eol, out_sof, out_eof, busy, done
  );
endinterface

// File: rtl/sgm_pipe_ctrl.sv
// Frame sequencer for a chain of clock-enabled delay stages: shared ce, per-stage valid
// tracking, output coordinates/markers aligned with the last stage, and a done pulse per frame.
module sgm_pipe_ctrl #(
  parameter int DEPTH  = 3,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic           clk,
  input  logic           rst,
  sgm_pipe_ctrl_if.slave bus
);
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             done_q, done_d;
  logic [DEPTH-1:0] sv_q, sv_d;

  logic ce;
  logic in_ready;
  logic in_beat;
  logic out_beat;
  logic at_eol;
  logic at_eof;
  logic last_in;

  assign at_eol   = (x_q == XW'(WIDTH - 1));
  assign at_eof   = at_eol && (y_q == YW'(HEIGHT - 1));
  // The chain only stalls when the last stage is occupied and downstream refuses it.
  assign ce       = (state_q != IDLE) && (bus.out_ready || !sv_q[DEPTH-1]);
  assign in_ready = (state_q == RUN) && ce;
  assign in_beat  = bus.in_valid && in_ready;
  assign out_beat = sv_q[DEPTH-1] && bus.out_ready;
  assign last_in  = in_beat && (in_cnt_q == CW'(TOTAL - 1));

  assign sv_d[0] = ce ? in_beat : sv_q[0];
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    assign sv_d[gi] = ce ? sv_q[gi-1] : sv_q[gi];
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (last_in) begin
          in_cnt_d = '0;
          state_d  = DRAIN;
        end else if (in_beat) begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_beat && at_eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (out_beat) begin
      if (at_eol) begin
        x_d = '0;
        y_d = at_eof ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      done_d = at_eof;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      sv_q     <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      done_q   <= done_d;
      sv_q     <= sv_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ce          = ce;
  assign bus.stage_valid = sv_q;
  assign bus.out_valid   = sv_q[DEPTH-1];
  assign bus.out_x       = x_q;
  assign bus.out_y       = y_q;
  assign bus.out_sol     = (x_q == '0);
  assign bus.out_eol     = at_eol;
  assign bus.out_sof     = (x_q == '0) && (y_q == '0);
  assign bus.out_eof     = at_eof;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
endmodule

// File: tb/tb_sgm_pipe_ctrl.sv
// Directed bench for sgm_pipe_ctrl with a 4x2 frame through a 3-deep chain.
module tb_sgm_pipe_ctrl;
  localparam int DEPTH  = 3;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic clk;
  logic rst;

  sgm_pipe_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  sgm_pipe_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc          = 0;
  bit mon_en       = 0;
  int in_beats     = 0;
  int out_cnt      = 0;
  int done_cnt     = 0;
  bit done_pending = 0;
  int first_in     = -1;
  int first_out    = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output scoreboard: beat k of a frame must sit at (k%WIDTH, k/WIDTH).
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int idx, ex, ey;
        if (in_beats == NPIX && bus.busy) check("in_ready_after_last", 32'(bus.in_ready), 0);
        if (bus.in_valid && bus.in_ready) begin
          if (first_in < 0) first_in = cyc;
          in_beats++;
        end
        check("done", 32'(bus.done), 32'(done_pending));
        if (bus.done) begin
          check("busy_at_done", 32'(bus.busy), 0);
          done_cnt++;
        end
        done_pending = 0;
        if (bus.out_valid && bus.out_ready) begin
          idx = out_cnt;
          ex  = idx % WIDTH;
          ey  = (idx / WIDTH) % HEIGHT;
          check("out_x", 32'(bus.out_x), ex);
          check("out_y", 32'(bus.out_y), ey);
          check("out_sol", 32'(bus.out_sol), 32'(ex == 0));
          check("out_eol", 32'(bus.out_eol), 32'(ex == WIDTH - 1));
          check("out_sof", 32'(bus.out_sof), 32'(idx == 0));
          check("out_eof", 32'(bus.out_eof), 32'(idx == NPIX - 1));
          if (first_out < 0) first_out = cyc;
          if (idx == NPIX - 1) done_pending = 1;
          out_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    in_beats  = 0;
    out_cnt   = 0;
    first_in  = -1;
    first_out = -1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_rise", 32'(bus.busy), 1);
  endtask

  task automatic wait_in(input int n, input int budget);
    int k = 0;
    while (in_beats < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_in_timeout", 32'(in_beats >= n), 1);
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (out_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_out_timeout", 32'(out_cnt >= n), 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k    = 0;
    int base = done_cnt;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt - base), 1);
    check({tag, "_in_beats"}, 32'(in_beats), NPIX);
    check({tag, "_out_beats"}, 32'(out_cnt), NPIX);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_ctrl", 32'({bus.in_ready, bus.ce, bus.out_valid, bus.busy, bus.done}), 0);
    check("rst_stage_valid", 32'(bus.stage_valid), 0);
    check("rst_xy", 32'({bus.out_x, bus.out_y}), 0);
    check("rst_sol_sof", 32'({bus.out_sol, bus.out_sof}), 32'b11);

    // Idle with in_valid but no start
    rst           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ctrl", 32'({bus.in_ready, bus.ce, bus.out_valid, bus.busy, bus.done}), 0);
    end
    $display("test reset_idle done");

    // Streaming frame
    mon_en = 1;
    start_frame();
    wait_done("stream", 60);
    check("stream_latency", 32'(first_out - first_in), DEPTH);
    $display("test streaming done");

    // Backpressure mid-frame
    start_frame();
    wait_out(3, 40);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ce", 32'(bus.ce), 0);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_stage_valid", 32'(bus.stage_valid), 32'b111);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_done("bp", 60);
    $display("test backpressure done");

    // Bubbles: in_valid alternates starting with 0 at the start edge
    bus.in_valid = 1'b0;
    start_frame();
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = ~bus.in_valid;
      if (i >= 3) check("bubble_alt", 32'(bus.stage_valid == 3'b101 || bus.stage_valid == 3'b010), 1);
      tick();
    end
    base = done_cnt;
    while (in_beats < NPIX && done_cnt == base) begin
      bus.in_valid = ~bus.in_valid;
      tick();
    end
    bus.in_valid = 1'b1;
    wait_done("bubble", 60);
    $display("test bubbles done");

    // Start re-pulsed during RUN and DRAIN
    base = done_cnt;
    start_frame();
    for (int i = 0; i < 4; i++) begin
      bus.start = (i % 2 == 1);
      tick();
    end
    bus.start = 1'b0;
    wait_in(NPIX, 40);
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("drain_busy", 32'(bus.busy), 1);
    check("drain_in_ready", 32'(bus.in_ready), 0);
    tick();
    bus.out_ready = 1'b1;
    wait_done("restart", 60);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("restart_idle_busy", 32'(bus.busy), 0);
    end
    check("restart_one_done", 32'(done_cnt - base), 1);
    $display("test start_ignored done");

    // Reset mid-frame
    start_frame();
    wait_in(5, 40);
    rst    = 1'b1;
    mon_en = 0;
    tick();
    check("midrst_ctrl", 32'({bus.in_ready, bus.ce, bus.out_valid, bus.busy, bus.done}), 0);
    check("midrst_stage_valid", 32'(bus.stage_valid), 0);
    check("midrst_xy", 32'({bus.out_x, bus.out_y}), 0);
    rst          = 1'b0;
    done_pending = 0;
    tick();
    check("midrst_idle", 32'(bus.busy), 0);
    mon_en = 1;
    start_frame();
    wait_done("midrst_frame", 60);
    $display("test reset_midframe done");

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
